// File: rtl/tt_um_serial_adder_seq.sv
// ---------------------------------------------------------------------------
// tt_um_serial_adder_seq
//
// Bit-serial adder. Two operands are loaded from ui_in, then a rising edge on
// the start control sums them LSB-first, one bit per clock, over NBITS cycles.
// The sum lands in R (uo_out) and the final carry is presented as cout.
//
// Parameters
//   NBITS    : number of operand bits summed per run (1..8)
//
// Ports
//   clk      : clock, all state on the rising edge
//   rst_n    : asynchronous active-low reset
//   ena      : power-good indicator, unused
//   ui_in    : operand data bus
//   uio_in   : [0] load_a, [1] load_b, [2] start, [3] cin, [7:4] unused
//   uo_out   : result register R
//   uio_out  : [4] busy, [5] done, [6] cout, [7] last serial sum bit,
//              [3:0] tied low
//   uio_oe   : constant 8'hF0 (upper nibble driven)
// ---------------------------------------------------------------------------
module tt_um_serial_adder_seq #(
  parameter int NBITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(NBITS - 1);

  // Control decode
  logic load_a;
  logic load_b;
  logic start;
  logic cin;
  logic any_load;
  logic start_evt;

  assign load_a   = uio_in[0];
  assign load_b   = uio_in[1];
  assign start    = uio_in[2];
  assign cin      = uio_in[3];
  assign any_load = load_a | load_b;

  // Registered state
  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] r_q, r_d;
  logic       c_q, c_d;
  logic [2:0] i_q, i_d;
  logic       sum_q, sum_d;
  logic       s_prev_q;
  logic       armed_q;
  logic       busy_q;
  logic       done_q;

  // armed_q stays low after reset until start has been seen low once, so a
  // start held high across reset release cannot look like a fresh edge even
  // though s_prev_q itself resets to 0.
  assign start_evt = start & ~s_prev_q & armed_q;

  // Serial bit slice
  logic bit_a;
  logic bit_b;
  logic bit_s;
  logic bit_c;

  always_comb begin
    bit_a = a_q[i_q];
    bit_b = b_q[i_q];
    bit_s = bit_a ^ bit_b ^ c_q;
    bit_c = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    c_d     = c_q;
    i_d     = i_q;
    sum_d   = sum_q;

    case (state_q)
      IDLE, DONE: begin
        if (any_load) begin
          // Loads win over a coincident start; that start is simply lost.
          if (load_a) a_d = ui_in;
          if (load_b) b_d = ui_in;
          state_d = IDLE;
        end else if (start_evt) begin
          state_d = RUN;
          c_d     = cin;
          i_d     = '0;
          r_d     = '0;
        end
      end

      RUN: begin
        // Only bits 0..NBITS-1 are ever indexed, so R above NBITS stays 0.
        r_d[i_q] = bit_s;
        c_d      = bit_c;
        sum_d    = bit_s;
        i_d      = i_q + 3'd1;
        if (i_q == LAST_IDX) begin
          state_d = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      r_q      <= '0;
      c_q      <= 1'b0;
      i_q      <= '0;
      sum_q    <= 1'b0;
      s_prev_q <= 1'b0;
      armed_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      r_q      <= r_d;
      c_q      <= c_d;
      i_q      <= i_d;
      sum_q    <= sum_d;
      s_prev_q <= start;
      if (!start) armed_q <= 1'b1;
      // Status flags registered from the next state so they track it exactly.
      busy_q   <= (state_d == RUN);
      done_q   <= (state_d == DONE);
    end
  end

  assign uo_out  = r_q;
  assign uio_out = {sum_q, c_q, done_q, busy_q, 4'b0000};
  assign uio_oe  = 8'hF0;

  logic unused_ok;
  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

endmodule
